// File: rtl/buzzer_pkg.sv
// Shared types and default widths for the buzzer pattern generator.
// Holds the FSM state enum and the default counter widths.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int DUR_W_DEF  = 16;
  localparam int BEEP_W_DEF = 8;

endpackage

// File: rtl/tone_phase_counter.sv
// Tone phase counter: tracks the position inside one tone period.
// Ports: clk, reset, restart (phase->0), run (advance), period, duty,
// tone (level for the NEXT cycle, to be registered by the caller).
module tone_phase_counter
  import buzzer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             tone
);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;
  logic             wrap;

  // Extra bit keeps phase+1 from overflowing for period=0.
  assign wrap = ({1'b0, phase_q} + (CNT_W+1)'(1))
                >= {1'b0, period};

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (run) begin
      phase_d = wrap ? '0 : phase_q + CNT_W'(1);
    end
  end

  // Level is derived from the next phase so the caller's
  // register shows it with no extra cycle of latency.
  always_comb begin
    tone = 1'b0;
    if (period < CNT_W'(2)) begin
      tone = 1'b0;
    end else if (duty >= period) begin
      tone = 1'b1;
    end else begin
      tone = (phase_d < duty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/buzzer_pattern_gen.sv
// Beep pattern generator: N gated tone beeps or a continuous train.
// Ports: clk, reset, start, stop, period, duty, on_len, off_len,
// beep_count (0 = continuous), busy, done, buzzer_signal.
// Optional macro BUZZER_MUTE_EN adds input mute (forces tone low).
module buzzer_pattern_gen
  import buzzer_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUR_W  = DUR_W_DEF,
  parameter int BEEP_W = BEEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  duty,
  input  logic [DUR_W-1:0]  on_len,
  input  logic [DUR_W-1:0]  off_len,
  input  logic [BEEP_W-1:0] beep_count,
`ifdef BUZZER_MUTE_EN
  input  logic              mute,
`endif
  output logic              busy,
  output logic              done,
  output logic              buzzer_signal
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [DUR_W-1:0]  on_q, on_d;
  logic [DUR_W-1:0]  off_q, off_d;
  logic [BEEP_W-1:0] bcnt_q, bcnt_d;

  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [BEEP_W-1:0] beeps_q, beeps_d;
  logic              done_q, done_d;
  logic              buz_q, buz_d;

  logic              load;
  logic [DUR_W-1:0]  on_eff;
  logic [DUR_W-1:0]  off_eff;
  logic              on_last;
  logic              off_last;
  logic              last_beep;
  logic [BEEP_W-1:0] beeps_inc;
  logic              run;
  logic              restart;
  logic              tone_nxt;
  logic              mute_w;

  assign load = (state_q == IDLE) && start && !stop;

  // Config feeds straight through on the load cycle so the
  // first ON cycle already sees the new tone settings.
  assign period_d = load ? period     : period_q;
  assign duty_d   = load ? duty       : duty_q;
  assign on_d     = load ? on_len     : on_q;
  assign off_d    = load ? off_len    : off_q;
  assign bcnt_d   = load ? beep_count : bcnt_q;

  assign on_eff  = (on_q  == '0) ? DUR_W'(1) : on_q;
  assign off_eff = (off_q == '0) ? DUR_W'(1) : off_q;

  assign on_last  = ({1'b0, dur_q} + (DUR_W+1)'(1))
                    >= {1'b0, on_eff};
  assign off_last = ({1'b0, dur_q} + (DUR_W+1)'(1))
                    >= {1'b0, off_eff};

  // Saturates so continuous mode never wraps back to zero.
  assign beeps_inc = (beeps_q == '1) ? beeps_q
                                     : beeps_q + BEEP_W'(1);

  assign last_beep = (bcnt_q != '0) &&
                     (({1'b0, beeps_q} + (BEEP_W+1)'(1))
                      >= {1'b0, bcnt_q});

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    beeps_d = beeps_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      dur_d   = '0;
      beeps_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ON;
            dur_d   = '0;
            beeps_d = '0;
          end
        end
        ON: begin
          if (on_last) begin
            dur_d   = '0;
            beeps_d = beeps_inc;
            if (last_beep) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = OFF;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        OFF: begin
          if (off_last) begin
            state_d = ON;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dur_d   = '0;
          beeps_d = '0;
        end
      endcase
    end
  end

  assign run     = (state_d == ON);
  assign restart = run && (state_q != ON);

  tone_phase_counter #(
    .CNT_W (CNT_W)
  ) u_tone (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .run     (run),
    .period  (period_d),
    .duty    (duty_d),
    .tone    (tone_nxt)
  );

`ifdef BUZZER_MUTE_EN
  assign mute_w = mute;
`else
  assign mute_w = 1'b0;
`endif

  assign buz_d = run && tone_nxt && !mute_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      duty_q   <= '0;
      on_q     <= '0;
      off_q    <= '0;
      bcnt_q   <= '0;
      dur_q    <= '0;
      beeps_q  <= '0;
      done_q   <= 1'b0;
      buz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      on_q     <= on_d;
      off_q    <= off_d;
      bcnt_q   <= bcnt_d;
      dur_q    <= dur_d;
      beeps_q  <= beeps_d;
      done_q   <= done_d;
      buz_q    <= buz_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign buzzer_signal = buz_q;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Directed bench for buzzer_pattern_gen.
// Cycle 0 is the cycle start is held; outputs sampled on negedge.
module tb_buzzer_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] period;
  logic [15:0] duty;
  logic [15:0] on_len;
  logic [15:0] off_len;
  logic [7:0]  beep_count;
`ifdef BUZZER_MUTE_EN
  logic        mute;
`endif
  logic        busy;
  logic        done;
  logic        buzzer_signal;

  int n_err = 0;
  int n_chk = 0;

  localparam logic [31:0] M_BUSY = 32'h001F_FFFE;
  localparam logic [31:0] M_DONE = 32'h0020_0000;
  localparam logic [31:0] M_BUZ  = 32'h0006_6066;
  localparam logic [31:0] M_FULL = 32'h001F_E1FE;

  always #5 clk = ~clk;

  buzzer_pattern_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .period        (period),
    .duty          (duty),
    .on_len        (on_len),
    .off_len       (off_len),
    .beep_count    (beep_count),
`ifdef BUZZER_MUTE_EN
    .mute          (mute),
`endif
    .busy          (busy),
    .done          (done),
    .buzzer_signal (buzzer_signal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic b, input logic d,
                      input logic z);
    check({tag, " busy"}, 32'(busy), 32'(b));
    check({tag, " done"}, 32'(done), 32'(d));
    check({tag, " buz"}, 32'(buzzer_signal), 32'(z));
  endtask

  // mode 0 plain, 1 start/input churn, 2 reset at cycle 5,
  // 3 mute held cycles 0..6
  task automatic run_pat(input string name,
                         input logic [15:0] p, input logic [15:0] d,
                         input logic [15:0] on, input logic [15:0] off,
                         input logic [7:0] bc,
                         input logic [31:0] m_busy,
                         input logic [31:0] m_buz,
                         input logic [31:0] m_done,
                         input int ncyc, input int mode);
    @(negedge clk);
    period = p; duty = d; on_len = on; off_len = off;
    beep_count = bc; start = 1'b1;
`ifdef BUZZER_MUTE_EN
    mute = (mode == 3);
`endif
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      chk3($sformatf("%s c%0d", name, c),
           m_busy[c], m_done[c], m_buz[c]);
      start = 1'b0;
      if (mode == 1 && (c == 3 || c == 7 || c == 12)) begin
        start = 1'b1;
        period = 16'($urandom); duty = 16'($urandom);
        on_len = 16'($urandom_range(1, 5));
        off_len = 16'($urandom_range(1, 5));
        beep_count = 8'($urandom_range(1, 3));
      end
      if (mode == 2 && c == 5) reset = 1'b1;
      if (mode == 2 && c == 6) reset = 1'b0;
`ifdef BUZZER_MUTE_EN
      if (mode == 3 && c == 6) mute = 1'b0;
`endif
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    period = '0; duty = '0; on_len = '0; off_len = '0;
    beep_count = '0;
`ifdef BUZZER_MUTE_EN
    mute = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk3("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_pat("basic", 4, 2, 8, 4, 2, M_BUSY, M_BUZ, M_DONE, 24, 0);
    run_pat("duty0", 4, 0, 8, 4, 2, M_BUSY, 32'h0, M_DONE, 24, 0);
    run_pat("duty9", 4, 9, 8, 4, 2, M_BUSY, M_FULL, M_DONE, 24, 0);
    run_pat("per1", 1, 2, 8, 4, 2, M_BUSY, 32'h0, M_DONE, 24, 0);
    run_pat("churn", 4, 2, 8, 4, 2, M_BUSY, M_BUZ, M_DONE, 24, 1);

    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    period = 4; duty = 2; on_len = 8; off_len = 4; beep_count = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk3($sformatf("ststp c%0d", i + 1), 1'b0, 1'b0, 1'b0);
    end

    run_pat("rst", 4, 2, 8, 4, 2, 32'h3E, 32'h26, 32'h0, 6, 2);
    run_pat("post", 4, 2, 8, 4, 2, M_BUSY, M_BUZ, M_DONE, 24, 0);

    @(negedge clk);
    period = 2; duty = 1; on_len = 3; off_len = 2;
    beep_count = 0; start = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk3($sformatf("cont c%0d", c), 1'b1, 1'b0,
           ((c - 1) % 5 == 0) || ((c - 1) % 5 == 2));
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk3("stop", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk3($sformatf("idle c%0d", i), 1'b0, 1'b0, 1'b0);
    end

`ifdef BUZZER_MUTE_EN
    run_pat("mute", 4, 2, 8, 4, 2, M_BUSY, 32'h0006_6000,
            M_DONE, 24, 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
